// File: rtl/uprog_pkg.sv
// uprog_pkg: field widths and word-field helpers for the micro-programmed sequencer.
package uprog_pkg;
    function automatic int aw(int sw, int iw);
        return sw + iw;
    endfunction
    function automatic int ww(int sw, int ow);
        return sw + ow;
    endfunction
    // Store word layout is {next, out}; words are at most 32 bits wide.
    function automatic logic [31:0] get_next(logic [31:0] w, int sw, int ow);
        return (w >> ow) & ((32'd1 << sw) - 32'd1);
    endfunction
    function automatic logic [31:0] get_out(logic [31:0] w, int ow);
        return w & ((32'd1 << ow) - 32'd1);
    endfunction
endpackage

// File: rtl/uprog_fsm_param_if.sv
// uprog_fsm_param_if: run/program bus between a host and the sequencer.
interface uprog_fsm_param_if #(
    parameter int SW = 2,
    parameter int IW = 2,
    parameter int OW = 2
);
    logic en;
    logic [IW-1:0] in;
    logic [SW-1:0] state;
    logic [OW-1:0] out;
    logic chg;
    logic err;
    logic pwe;
    logic [SW+IW-1:0] paddr;
    logic [SW+OW-1:0] pdata;
    modport master(output en, in, pwe, paddr, pdata, input state, out, chg, err);
    modport slave(input en, in, pwe, paddr, pdata, output state, out, chg, err);
endinterface

// File: rtl/uprog_store.sv
// uprog_store: writable control store with per-word valid bits, async read port.
module uprog_store #(
    parameter int AW = 4,
    parameter int WW = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [WW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [WW-1:0] rdata,
    output logic          rvalid
);
    logic [WW-1:0] mem [2**AW];
    logic [2**AW-1:0] valid;
    // Data bits carry no reset; writes are dropped while clr is held low.
    always_ff @(posedge clk)
        if (clr && we) mem[waddr] <= wdata;
    always_ff @(posedge clk or negedge clr)
        if (!clr) valid <= '0;
        else if (we) valid[waddr] <= 1'b1;
    assign rdata = mem[raddr];
    assign rvalid = valid[raddr];
endmodule

// File: rtl/uprog_fsm_param.sv
// uprog_fsm_param: micro-programmed Moore sequencer; store word {next, out} fetched at {state, in}.
module uprog_fsm_param
    import uprog_pkg::*;
#(
    parameter int SW = 2,
    parameter int IW = 2,
    parameter int OW = 2,
    parameter logic [SW-1:0] RST_STATE = '0,
    parameter logic [OW-1:0] RST_OUT = '0
) (
    input logic clk,
    input logic clr,
    uprog_fsm_param_if.slave bus
);
    localparam int AW = aw(SW, IW);
    localparam int WW = ww(SW, OW);
    logic [SW-1:0] state_q;
    logic [OW-1:0] out_q;
    logic chg_q, err_q;
    logic [WW-1:0] rdata;
    logic rvalid;
    logic [SW-1:0] nxt;
    logic [OW-1:0] nout;
    uprog_store #(.AW(AW), .WW(WW)) u_store (
        .clk(clk),
        .clr(clr),
        .we(bus.pwe),
        .waddr(bus.paddr),
        .wdata(bus.pdata),
        .raddr({state_q, bus.in}),
        .rdata(rdata),
        .rvalid(rvalid)
    );
    assign nxt = SW'(get_next(32'(rdata), SW, OW));
    assign nout = OW'(get_out(32'(rdata), OW));
    // Store read is combinational and the write lands at the edge, so a same-edge fetch sees the old word.
    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            state_q <= RST_STATE;
            out_q <= RST_OUT;
            chg_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            chg_q <= 1'b0;
            if (bus.en && rvalid) begin
                state_q <= nxt;
                out_q <= nout;
                chg_q <= nxt != state_q;
            end else if (bus.en) err_q <= 1'b1;
        end
    assign bus.state = state_q;
    assign bus.out = out_q;
    assign bus.chg = chg_q;
    assign bus.err = err_q;
endmodule

// File: tb/tb_uprog_fsm_param.sv
// tb_uprog_fsm_param: directed scenarios plus randomized run against a store/state model.
module tb_uprog_fsm_param;
    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;
    uprog_fsm_param_if #(.SW(2), .IW(2), .OW(2)) bus();
    uprog_fsm_param #(.SW(2), .IW(2), .OW(2), .RST_STATE(2'd0), .RST_OUT(2'b01)) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus.slave)
    );
    int tests = 0;
    int fails = 0;
    logic [3:0] ms [16];
    bit mv [16];
    logic [1:0] mst, mo;
    bit mchg, merr;
    logic [1:0] moore [4] = '{2'b01, 2'b11, 2'b00, 2'b11};
    // Example program: each word carries the Moore output of its destination state.
    function automatic logic [3:0] prog(int a);
        logic [1:0] s, i, n;
        s = 2'(a >> 2);
        i = 2'(a);
        n = s == 0 ? (i[0] ? 2'd2 : 2'd1) : s == 1 ? 2'd3 : s == 2 ? (i[1] ? 2'd2 : 2'd1) : (i[0] ? 2'd0 : 2'd2);
        return {n, moore[n]};
    endfunction
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic check_all();
        check("state", 32'(bus.state), 32'(mst));
        check("out", 32'(bus.out), 32'(mo));
        check("chg", 32'(bus.chg), 32'(mchg));
        check("err", 32'(bus.err), 32'(merr));
    endtask
    task automatic model_reset();
        mst = 2'd0;
        mo = 2'b01;
        mchg = 0;
        merr = 0;
        foreach (mv[i]) mv[i] = 0;
    endtask
    task automatic model_edge();
        int a;
        bit ov;
        logic [3:0] ow;
        if (!clr) return;
        a = {mst, bus.in};
        ov = mv[a];
        ow = ms[a];
        if (bus.pwe) begin
            ms[bus.paddr] = bus.pdata;
            mv[bus.paddr] = 1;
        end
        if (!bus.en) mchg = 0;
        else if (!ov) begin
            mchg = 0;
            merr = 1;
        end else begin
            mchg = ow[3:2] != mst;
            mst = ow[3:2];
            mo = ow[1:0];
        end
    endtask
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask
    task automatic reset_now();
        #2;
        clr = 1'b0;
        model_reset();
        #1;
        check_all();
    endtask
    task automatic release_rst();
        @(negedge clk);
        clr = 1'b1;
    endtask
    task automatic load(int skip);
        bus.en = 1'b0;
        for (int a = 0; a < 16; a++)
            if (a != skip) begin
                bus.pwe = 1'b1;
                bus.paddr = 4'(a);
                bus.pdata = prog(a);
                tick();
            end
        bus.pwe = 1'b0;
    endtask
    task automatic lit(string name, logic [1:0] s, logic [1:0] o, bit c, bit e);
        check({name, ".state"}, 32'(bus.state), 32'(s));
        check({name, ".out"}, 32'(bus.out), 32'(o));
        check({name, ".chg"}, 32'(bus.chg), 32'(c));
        check({name, ".err"}, 32'(bus.err), 32'(e));
    endtask
    initial begin
        logic [1:0] seq_s [4] = '{2'd1, 2'd3, 2'd2, 2'd1};
        logic [1:0] seq_o [4] = '{2'b11, 2'b11, 2'b00, 2'b11};
        bus.en = 1'b0;
        bus.in = '0;
        bus.pwe = 1'b0;
        bus.paddr = '0;
        bus.pdata = '0;
        // 1: asynchronous reset before any clock edge
        #3;
        clr = 1'b0;
        model_reset();
        #1;
        lit("reset", 2'd0, 2'b01, 0, 0);
        check_all();
        release_rst();
        // 2: full program, run with IN=00
        load(-1);
        bus.en = 1'b1;
        bus.in = 2'b00;
        for (int k = 0; k < 4; k++) begin
            tick();
            lit("run", seq_s[k], seq_o[k], 1, 0);
        end
        // 3: self-loop in state 2
        tick();
        tick();
        bus.in = 2'b10;
        for (int k = 0; k < 3; k++) begin
            tick();
            lit("selfloop", 2'd2, 2'b00, 0, 0);
        end
        // 4: unprogrammed word {3,01}
        reset_now();
        release_rst();
        load(13);
        bus.en = 1'b1;
        bus.in = 2'b00;
        tick();
        tick();
        lit("pre_err", 2'd3, 2'b11, 1, 0);
        bus.in = 2'b01;
        tick();
        lit("err_set", 2'd3, 2'b11, 0, 1);
        bus.in = 2'b00;
        tick();
        lit("err_sticky", 2'd2, 2'b00, 1, 1);
        tick();
        reset_now();
        lit("err_clr", 2'd0, 2'b01, 0, 0);
        release_rst();
        // 5: write/fetch collision at {1,00}
        load(-1);
        bus.en = 1'b1;
        bus.in = 2'b00;
        tick();
        bus.pwe = 1'b1;
        bus.paddr = 4'd4;
        bus.pdata = 4'b0010;
        tick();
        bus.pwe = 1'b0;
        lit("collide_old", 2'd3, 2'b11, 1, 0);
        tick();
        tick();
        tick();
        lit("collide_new", 2'd0, 2'b10, 1, 0);
        // 6: hold with EN=0, then reset mid-run clears valid bits
        bus.en = 1'b0;
        bus.pwe = 1'b1;
        bus.paddr = 4'd4;
        bus.pdata = prog(4);
        tick();
        bus.pwe = 1'b0;
        bus.en = 1'b1;
        tick();
        tick();
        bus.en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            lit("hold", 2'd3, 2'b11, 0, 0);
        end
        reset_now();
        lit("midreset", 2'd0, 2'b01, 0, 0);
        release_rst();
        bus.en = 1'b1;
        tick();
        lit("after_reset", 2'd0, 2'b01, 0, 1);
        // randomized run
        reset_now();
        release_rst();
        for (int k = 0; k < 1500; k++) begin
            bus.en = $urandom_range(0, 3) != 0;
            bus.in = 2'($urandom);
            bus.pwe = $urandom_range(0, 3) == 0;
            bus.paddr = 4'($urandom);
            bus.pdata = 4'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                reset_now();
                release_rst();
            end
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
